hazard_stall_controller: RTL and testbench

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

---
 rtl/hazard_stall_controller.sv | 199 +++++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Purpose : pipeline hazard controller. It produces load-use stalls, taken-branch flushes,
//           data-memory wait freezes and a sticky memory-timeout error state.
// Latency : the control outputs are combinational in the current state and inputs, so each
//           action takes effect in the cycle its condition appears. State and counters
//           update on the next rising edge.
// Backpr. : the controller is the backpressure source. PCWrite/IF_ID_Write/ID_EX_Write/
//           EX_MEM_Write = 0 holds the pipeline. It accepts no backpressure itself.
//
// Ports:
//   clk, reset                      - single clock; synchronous active-high reset
//   ID_EX_MemRead, ID_EX_RegisterRt - load in EX and its destination register
//   IF_ID_RegisterRs/Rt             - source registers of the instruction in ID
//   Branch_Taken                    - branch/jump resolved taken in EX
//   MEM_Req, MEM_Ready              - data-memory access active / access complete
//   PCWrite..EX_MEM_Write           - pipeline register load enables
//   IF_ID_Flush, ID_EX_Flush        - zero the control fields of IF/ID and ID/EX
//   MEM_WB_Bubble                   - insert a bubble into MEM/WB
//   State                           - 00 RUN, 01 MEM_WAIT, 10 ERROR
//   Stall_Cycles                    - saturating count of cycles with PCWrite=0 (not in ERROR)
//   Mem_Timeout                     - sticky flag, set on entry to ERROR

module hazard_stall_controller #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_RegisterRt,
    input  logic [4:0]  IF_ID_RegisterRs,
    input  logic [4:0]  IF_ID_RegisterRt,
    input  logic        Branch_Taken,
    input  logic        MEM_Req,
    input  logic        MEM_Ready,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        ID_EX_Write,
    output logic        EX_MEM_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        MEM_WB_Bubble,
    output logic [1:0]  State,
    output logic [15:0] Stall_Cycles,
    output logic        Mem_Timeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic [7:0]  w_wait_cnt_inc;
    logic [15:0] r_stall_cnt;
    logic        r_mem_timeout;
    logic        w_set_timeout;

    logic        w_load_use;
    logic        w_pc_write;
    logic        w_if_id_write;
    logic        w_id_ex_write;
    logic        w_ex_mem_write;
    logic        w_if_id_flush;
    logic        w_id_ex_flush;
    logic        w_mem_wb_bubble;
    logic        w_count_stall;

    // Register $zero never creates a dependency, so a load targeting it cannot stall.
    assign w_load_use = ID_EX_MemRead
                     && (ID_EX_RegisterRt != 5'd0)
                     && ((ID_EX_RegisterRt == IF_ID_RegisterRs)
                      || (ID_EX_RegisterRt == IF_ID_RegisterRt));

    assign w_wait_cnt_inc = r_wait_cnt + 8'd1;

    // Next-state and output decode.
    always_comb begin
        // Defaults: run freely, keep the current state and the wait count.
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_set_timeout   = 1'b0;
        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_id_ex_write   = 1'b1;
        w_ex_mem_write  = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_mem_wb_bubble = 1'b0;

        // While reset is high the defaults are driven. The registers are reset at the
        // edge, so the next-state values computed here are never used.
        if (!reset) begin
            unique case (r_state)
                ST_RUN: begin
                    if (MEM_Req && !MEM_Ready) begin
                        // Memory freeze has top priority. Hold everything and bubble MEM/WB.
                        w_pc_write      = 1'b0;
                        w_if_id_write   = 1'b0;
                        w_id_ex_write   = 1'b0;
                        w_ex_mem_write  = 1'b0;
                        w_mem_wb_bubble = 1'b1;
                        w_state_nxt     = ST_MEM_WAIT;
                        w_wait_cnt_nxt  = 8'd0;
                    end else if (Branch_Taken) begin
                        // Taken branch squashes the wrong-path instructions in IF/ID and ID/EX.
                        // A load-use hazard against a squashed instruction does not matter.
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end else if (w_load_use) begin
                        // Hold PC and IF/ID for one cycle and send a bubble into EX.
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_id_ex_flush = 1'b1;
                    end
                end

                ST_MEM_WAIT: begin
                    if (!MEM_Ready) begin
                        // Still frozen. Branch and load-use wait until the memory completes.
                        w_pc_write      = 1'b0;
                        w_if_id_write   = 1'b0;
                        w_id_ex_write   = 1'b0;
                        w_ex_mem_write  = 1'b0;
                        w_mem_wb_bubble = 1'b1;
                        w_wait_cnt_nxt  = w_wait_cnt_inc;
                        if (w_wait_cnt_inc == MEM_TIMEOUT) begin
                            w_state_nxt   = ST_ERROR;
                            w_set_timeout = 1'b1;
                        end
                    end else begin
                        // Release cycle. Decode as in RUN, except that no freeze is possible.
                        // MEM_Ready wins over a timeout that lands on the same cycle.
                        w_state_nxt = ST_RUN;
                        if (Branch_Taken) begin
                            w_if_id_flush = 1'b1;
                            w_id_ex_flush = 1'b1;
                        end else if (w_load_use) begin
                            w_pc_write    = 1'b0;
                            w_if_id_write = 1'b0;
                            w_id_ex_flush = 1'b1;
                        end
                    end
                end

                ST_ERROR: begin
                    // Terminal until reset. Pipeline held, nothing retires.
                    w_pc_write      = 1'b0;
                    w_if_id_write   = 1'b0;
                    w_id_ex_write   = 1'b0;
                    w_ex_mem_write  = 1'b0;
                    w_mem_wb_bubble = 1'b1;
                end

                default: begin
                    // Unreachable encoding. Recover to RUN.
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Stall counting covers RUN and MEM_WAIT only. ERROR cycles are not stalls.
    assign w_count_stall = !reset
                        && !w_pc_write
                        && ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_stall_cnt   <= 16'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_count_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_set_timeout) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign PCWrite       = w_pc_write;
    assign IF_ID_Write   = w_if_id_write;
    assign ID_EX_Write   = w_id_ex_write;
    assign EX_MEM_Write  = w_ex_mem_write;
    assign IF_ID_Flush   = w_if_id_flush;
    assign ID_EX_Flush   = w_id_ex_flush;
    assign MEM_WB_Bubble = w_mem_wb_bubble;
    assign State         = r_state;
    assign Stall_Cycles  = r_stall_cnt;
    assign Mem_Timeout   = r_mem_timeout;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Purpose : directed bench for hazard_stall_controller instantiated with MEM_TIMEOUT=4.
// Latency : combinational outputs are sampled before the rising edge. State, Stall_Cycles
//           and Mem_Timeout are sampled 1ns after the edge.
// Backpr. : not applicable; the bench drives every input each cycle.

module tb_hazard_stall_controller;

    logic        clk;
    logic        reset;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_RegisterRt;
    logic [4:0]  IF_ID_RegisterRs;
    logic [4:0]  IF_ID_RegisterRt;
    logic        Branch_Taken;
    logic        MEM_Req;
    logic        MEM_Ready;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        ID_EX_Write;
    logic        EX_MEM_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic        MEM_WB_Bubble;
    logic [1:0]  State;
    logic [15:0] Stall_Cycles;
    logic        Mem_Timeout;

    hazard_stall_controller #(.MEM_TIMEOUT(8'd4)) dut (
        .clk              (clk),
        .reset            (reset),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .Branch_Taken     (Branch_Taken),
        .MEM_Req          (MEM_Req),
        .MEM_Ready        (MEM_Ready),
        .PCWrite          (PCWrite),
        .IF_ID_Write      (IF_ID_Write),
        .ID_EX_Write      (ID_EX_Write),
        .EX_MEM_Write     (EX_MEM_Write),
        .IF_ID_Flush      (IF_ID_Flush),
        .ID_EX_Flush      (ID_EX_Flush),
        .MEM_WB_Bubble    (MEM_WB_Bubble),
        .State            (State),
        .Stall_Cycles     (Stall_Cycles),
        .Mem_Timeout      (Mem_Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output patterns, ordered {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
    // IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble}.
    localparam logic [6:0] O_DEF = 7'b1111_000;
    localparam logic [6:0] O_FRZ = 7'b0000_001;
    localparam logic [6:0] O_BRF = 7'b1111_110;
    localparam logic [6:0] O_LU  = 7'b0011_010;

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_MW  = 2'b01;
    localparam logic [1:0] S_ERR = 2'b10;

    typedef struct {
        logic [6:0]  outs;
        logic [1:0]  state;
        logic [15:0] stall;
        logic        tmo;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  mdl_state = S_RUN;
    logic [15:0] mdl_stall = 16'd0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, push the expectation, then pop and compare it.
    task automatic step(input string tag,
                        input logic rst, input logic mr, input logic [4:0] exrt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic br,
                        input logic req, input logic rdy,
                        input logic [6:0] eo, input logic [1:0] ens, input logic etmo);
        exp_t e;
        @(negedge clk);
        reset            = rst;
        ID_EX_MemRead    = mr;
        ID_EX_RegisterRt = exrt;
        IF_ID_RegisterRs = rs;
        IF_ID_RegisterRt = rt;
        Branch_Taken     = br;
        MEM_Req          = req;
        MEM_Ready        = rdy;
        // Stall count model: PCWrite=0 outside ERROR adds one (saturating); reset clears.
        if (rst) begin
            mdl_stall = 16'd0;
        end else if (!eo[6] && mdl_state != S_ERR && mdl_stall != 16'hFFFF) begin
            mdl_stall = mdl_stall + 16'd1;
        end
        mdl_state = ens;
        sb_q.push_back('{outs: eo, state: ens, stall: mdl_stall, tmo: etmo});
        #1;
        e = sb_q.pop_front();
        chk({tag, ".outs"}, {9'd0, PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                             IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble}, {9'd0, e.outs});
        @(posedge clk);
        #1;
        chk({tag, ".state"}, {14'd0, State}, {14'd0, e.state});
        chk({tag, ".stall"}, Stall_Cycles, e.stall);
        chk({tag, ".tmo"}, {15'd0, Mem_Timeout}, {15'd0, e.tmo});
    endtask

    initial begin
        reset = 1'b1; ID_EX_MemRead = 1'b0; ID_EX_RegisterRt = 5'd0;
        IF_ID_RegisterRs = 5'd0; IF_ID_RegisterRt = 5'd0;
        Branch_Taken = 1'b0; MEM_Req = 1'b0; MEM_Ready = 1'b0;

        //   tag          rst mr exrt  rs     rt     br req rdy outs   next   tmo
        step("rst0",      1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_DEF, S_RUN, 0);
        // A freeze request under reset still gives the default outputs.
        step("rst_frzin", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_DEF, S_RUN, 0);
        step("idle",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_DEF, S_RUN, 0);

        // Load-use hazard
        step("lu_rs",     0, 1, 5'd5, 5'd5, 5'd1, 0, 0, 0, O_LU,  S_RUN, 0);
        step("lu_rt",     0, 1, 5'd7, 5'd2, 5'd7, 0, 0, 0, O_LU,  S_RUN, 0);
        step("lu_r0",     0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_DEF, S_RUN, 0);
        step("lu_nomat",  0, 1, 5'd5, 5'd6, 5'd4, 0, 0, 0, O_DEF, S_RUN, 0);
        step("lu_noload", 0, 0, 5'd5, 5'd5, 5'd5, 0, 0, 0, O_DEF, S_RUN, 0);

        // A branch outranks load-use, so the stall count does not move.
        step("br_lu",     0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, O_BRF, S_RUN, 0);
        step("mem_ready", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, O_DEF, S_RUN, 0);

        // Memory wait: MEM_Ready low for 3 cycles, then high.
        step("mw_f1",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("mw_f2",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("mw_f3",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("mw_rel",    0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, O_DEF, S_RUN, 0);

        // Branch and load-use held through a wait: freeze outranks both, then the
        // branch flush is taken in the release cycle.
        step("brw_f1",    0, 1, 5'd3, 5'd3, 5'd0, 1, 1, 0, O_FRZ, S_MW,  0);
        step("brw_f2",    0, 1, 5'd3, 5'd3, 5'd0, 1, 1, 0, O_FRZ, S_MW,  0);
        step("brw_f3",    0, 1, 5'd3, 5'd3, 5'd0, 1, 1, 0, O_FRZ, S_MW,  0);
        step("brw_rel",   0, 1, 5'd3, 5'd3, 5'd0, 1, 1, 1, O_BRF, S_RUN, 0);

        // Load-use is taken in the release cycle.
        step("luw_f1",    0, 1, 5'd9, 5'd0, 5'd9, 0, 1, 0, O_FRZ, S_MW,  0);
        step("luw_rel",   0, 1, 5'd9, 5'd0, 5'd9, 0, 1, 1, O_LU,  S_RUN, 0);

        // MEM_Ready on the 4th MEM_WAIT cycle wins over the timeout.
        step("tv_f0",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("tv_w1",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("tv_w2",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("tv_w3",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("tv_w4rdy",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, O_DEF, S_RUN, 0);

        // Timeout: 4 MEM_WAIT cycles without MEM_Ready lead to ERROR.
        step("to_f0",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("to_w1",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("to_w2",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("to_w3",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("to_w4",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_ERR, 1);
        // ERROR holds and ignores branch, load-use and MEM_Ready; the stall count is frozen.
        step("err_br",    0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, O_FRZ, S_ERR, 1);
        step("err_rdy",   0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, O_FRZ, S_ERR, 1);

        // Reset in ERROR
        step("err_rst",   1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_DEF, S_RUN, 0);
        step("post_rst1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_DEF, S_RUN, 0);

        // Reset in the middle of a freeze
        step("mr_f0",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("mr_f1",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("mr_rst",    1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_DEF, S_RUN, 0);
        step("post_rst2", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_DEF, S_RUN, 0);

        // The wait counter starts again from zero after the reset.
        step("rt_f0",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("rt_w1",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("rt_w2",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("rt_w3",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_MW,  0);
        step("rt_w4",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FRZ, S_ERR, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
